mmio_peripheral: RTL and testbench

- Memory-mapped peripheral block consumed by the MEM stage, selected when the address has bit 30 set.
- Provides an interval timer with interrupt, LED/switch/7-segment I/O and a byte UART (8N1).
- Returns read data combinationally in the same cycle as the MEM-stage access.
- Raises IRQ toward Control; IRQ is masked while the CPU is in kernel mode (PC[31]=1).

---
 rtl/mmio_peripheral_pkg.sv | 36 +++
 rtl/mmio_peripheral_uart_core.sv | 193 +++++++++++++++++++
 rtl/mmio_peripheral.sv | 131 +++++++++++++
 tb/tb_mmio_peripheral.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_peripheral_pkg.sv
// Purpose: shared register map, status bit positions and UART state encoding for mmio_peripheral.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mmio_peripheral_pkg;

  // Word offsets, compared against addr[5:2]
  localparam logic [3:0] REG_TH     = 4'h0;
  localparam logic [3:0] REG_TL     = 4'h1;
  localparam logic [3:0] REG_TCON   = 4'h2;
  localparam logic [3:0] REG_LED    = 4'h3;
  localparam logic [3:0] REG_SWITCH = 4'h4;
  localparam logic [3:0] REG_DIGI   = 4'h5;
  localparam logic [3:0] REG_TXD    = 4'h6;
  localparam logic [3:0] REG_RXD    = 4'h7;
  localparam logic [3:0] REG_UCON   = 4'h8;

  // TCON bits
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  // UCON bits
  localparam int UCON_TX_BUSY   = 0;
  localparam int UCON_RX_VALID  = 1;
  localparam int UCON_TX_DONE   = 2;
  localparam int UCON_FRAME_ERR = 3;
  localparam int UCON_OVERRUN   = 4;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/mmio_peripheral_uart_core.sv
// Purpose: 8N1 byte UART (TX and RX FSMs, baud counters, 2-FF RX synchronizer) with status flags.
// Latency: TX frame is 10 bit periods from start strobe to tx_done; rx_valid 2 cycles after the raw stop-bit sample point.
// Backpressure: tx_start is ignored while tx_busy; a new RX byte overwrites an unread one and flags overrun.
// Ports: clk/reset; tx_start, tx_byte (launch); rx_read (clears rx_valid), status_read (clears sticky flags);
//        rx_in/tx_out serial lines; tx_busy, tx_done, rx_valid, frame_err, overrun, rx_byte status/data.
module mmio_peripheral_uart_core
  import mmio_peripheral_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  input  logic       rx_read,
  input  logic       status_read,
  input  logic       rx_in,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic [7:0] rx_byte
);

  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

  // ---------------- TX ----------------
  uart_state_t   tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          tx_line_n;
  logic          tx_fin;

  assign tx_busy = (tx_state != UART_IDLE);

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = (tx_cnt == BIT_END) ? '0 : tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_line_n  = tx_out;
    tx_fin     = 1'b0;
    case (tx_state)
      UART_IDLE: begin
        tx_cnt_n = '0;
        if (tx_start) begin
          tx_state_n = UART_START;
          tx_sh_n    = tx_byte;
          tx_line_n  = 1'b0;
        end
      end
      UART_START: begin
        if (tx_cnt == BIT_END) begin
          tx_state_n = UART_DATA;
          tx_bit_n   = 3'd0;
          tx_line_n  = tx_sh[0];
        end
      end
      UART_DATA: begin
        if (tx_cnt == BIT_END) begin
          if (tx_bit == 3'd7) begin
            tx_state_n = UART_STOP;
            tx_line_n  = 1'b1;
          end else begin
            tx_sh_n   = {1'b0, tx_sh[7:1]};
            tx_line_n = tx_sh[1];
            tx_bit_n  = tx_bit + 3'd1;
          end
        end
      end
      UART_STOP: begin
        if (tx_cnt == BIT_END) begin
          tx_state_n = UART_IDLE;
          tx_line_n  = 1'b1;
          tx_fin     = 1'b1;
        end
      end
      default: tx_state_n = UART_IDLE;
    endcase
  end

  // Line is registered so it cannot glitch on state decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= UART_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_sh    <= 8'd0;
      tx_out   <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      tx_out   <= tx_line_n;
      if (tx_fin)           tx_done <= 1'b1;
      else if (status_read) tx_done <= 1'b0;
    end
  end

  // ---------------- RX ----------------
  logic          rx_s1, rx_s2, rx_prev;
  uart_state_t   rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic          rx_ok, rx_bad;

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_ok      = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state)
      UART_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_s2) rx_state_n = UART_START;
      end
      UART_START: begin
        // Mid-start-bit check rejects short low glitches.
        if (rx_cnt == HALF_END) begin
          rx_cnt_n = '0;
          if (rx_s2) begin
            rx_state_n = UART_IDLE;
          end else begin
            rx_state_n = UART_DATA;
            rx_bit_n   = 3'd0;
          end
        end
      end
      UART_DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s2, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_state_n = UART_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end
      end
      UART_STOP: begin
        if (rx_cnt == BIT_END) begin
          rx_state_n = UART_IDLE;
          rx_cnt_n   = '0;
          if (rx_s2) rx_ok  = 1'b1;
          else       rx_bad = 1'b1;
        end
      end
      default: rx_state_n = UART_IDLE;
    endcase
  end

  // Synchronizer and edge-detect history preset high (idle line) so reset release is not a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= UART_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= 3'd0;
      rx_sh     <= 8'd0;
      rx_byte   <= 8'd0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_s1    <= rx_in;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      if (rx_ok) rx_byte <= rx_sh;
      // Hardware sets win over same-cycle read clears.
      if (rx_ok)        rx_valid <= 1'b1;
      else if (rx_read) rx_valid <= 1'b0;
      if (rx_ok && rx_valid) overrun <= 1'b1;
      else if (status_read)  overrun <= 1'b0;
      if (rx_bad)           frame_err <= 1'b1;
      else if (status_read) frame_err <= 1'b0;
    end
  end

endmodule

// File: rtl/mmio_peripheral.sv
// Purpose: MEM-stage peripheral: interval timer with IRQ, LED/switch/7-seg registers, 8N1 UART.
// Latency: reads combinational in the access cycle; writes and read side effects at that cycle's rising edge.
// Backpressure: none; TXD writes while the transmitter is busy are dropped.
// Ports: clk/reset; rd, wr, addr (addr[5:2] decoded), wdata, rdata; supervisor masks irq;
//        led, digi outputs; switch input; uart_rx/uart_tx serial lines.
module mmio_peripheral
  import mmio_peripheral_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        supervisor,
  output logic        irq,
  output logic [7:0]  led,
  input  logic [7:0]  switch,
  output logic [11:0] digi,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  // Block select (addr[30]) is resolved upstream; only the word offset matters here.
  logic [3:0] off;
  logic       unused_addr;
  assign off         = addr[5:2];
  assign unused_addr = ^{addr[31:6], addr[1:0]};

  // A write wins when rd and wr collide, so read side effects need rd alone.
  logic rd_act;
  assign rd_act = rd & ~wr;

  logic wr_th, wr_tl, wr_tcon, wr_led, wr_digi, wr_txd;
  assign wr_th   = wr && (off == REG_TH);
  assign wr_tl   = wr && (off == REG_TL);
  assign wr_tcon = wr && (off == REG_TCON);
  assign wr_led  = wr && (off == REG_LED);
  assign wr_digi = wr && (off == REG_DIGI);
  assign wr_txd  = wr && (off == REG_TXD);

  logic [31:0] th, tl;
  logic [2:0]  tcon;
  logic [7:0]  txd;
  logic        tl_wrap;

  logic       tx_busy, tx_done, rx_valid, frame_err, overrun;
  logic [7:0] rx_byte;

  assign tl_wrap = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= 32'd0;
      tl   <= 32'd0;
      tcon <= 3'd0;
      led  <= 8'd0;
      digi <= 12'd0;
      txd  <= 8'd0;
    end else begin
      if (wr_th) th <= wdata;
      // A CPU write to TL overrides counting/reload for that cycle.
      if (wr_tl)                tl <= wdata;
      else if (tcon[TCON_EN])   tl <= tl_wrap ? th : tl + 32'd1;
      if (wr_tcon)
        tcon <= wdata[2:0];
      else if (tl_wrap && !wr_tl && tcon[TCON_IE])
        tcon[TCON_ST] <= 1'b1;
      if (wr_led)  led  <= wdata[7:0];
      if (wr_digi) digi <= wdata[11:0];
      // Mirrors the byte actually accepted by the transmitter.
      if (wr_txd && !tx_busy) txd <= wdata[7:0];
    end
  end

  assign irq = tcon[TCON_IE] & tcon[TCON_ST] & ~supervisor;

  mmio_peripheral_uart_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk        (clk),
    .reset      (reset),
    .tx_start   (wr_txd),
    .tx_byte    (wdata[7:0]),
    .rx_read    (rd_act && (off == REG_RXD)),
    .status_read(rd_act && (off == REG_UCON)),
    .rx_in      (uart_rx),
    .tx_out     (uart_tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .rx_byte    (rx_byte)
  );

  logic [4:0] ucon;
  always_comb begin
    ucon = 5'd0;
    ucon[UCON_TX_BUSY]   = tx_busy;
    ucon[UCON_RX_VALID]  = rx_valid;
    ucon[UCON_TX_DONE]   = tx_done;
    ucon[UCON_FRAME_ERR] = frame_err;
    ucon[UCON_OVERRUN]   = overrun;
  end

  always_comb begin
    rdata = 32'd0;
    if (rd) begin
      case (off)
        REG_TH:     rdata = th;
        REG_TL:     rdata = tl;
        REG_TCON:   rdata = {29'd0, tcon};
        REG_LED:    rdata = {24'd0, led};
        REG_SWITCH: rdata = {24'd0, switch};
        REG_DIGI:   rdata = {20'd0, digi};
        REG_TXD:    rdata = {24'd0, txd};
        REG_RXD:    rdata = {24'd0, rx_byte};
        REG_UCON:   rdata = {27'd0, ucon};
        default:    rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_peripheral.sv
// Purpose: self-checking bench for mmio_peripheral (timer, I/O regs, UART TX/RX, reset).
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_mmio_peripheral;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        supervisor = 1'b0;
  logic [7:0]  switch = 8'd0;
  logic        uart_rx = 1'b1;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        uart_tx;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic        tx_q[$];
  logic [7:0]  rx_q[$];

  always #5 clk = ~clk;

  // CLKS_PER_BIT = 4
  mmio_peripheral #(.CLK_HZ(4), .BAUD(1)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .supervisor(supervisor), .irq(irq), .led(led), .switch(switch),
    .digi(digi), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Both access tasks start and end on a falling edge.
  task automatic wr_reg(input logic [5:0] a, input logic [31:0] d);
    wr = 1'b1; addr = 32'h4000_0000 | {26'd0, a}; wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic rd_reg(input string tag, input logic [5:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    rd = 1'b1; addr = 32'h4000_0000 | {26'd0, a};
    #1;
    chk(tag, rdata, exp_q.pop_front());
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (4) @(negedge clk);
    end
    uart_rx = 1'b1;
    if (stop_bit) rx_q.push_back(b);
    repeat (4) @(negedge clk);
  endtask

  // An unread byte overwritten by a newer one is dropped from the scoreboard.
  task automatic rd_rxd(input string tag);
    logic [7:0] e;
    while (rx_q.size() > 1) void'(rx_q.pop_front());
    if (rx_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s no expected rx byte queued", tag);
    end else begin
      e = rx_q.pop_front();
      rd_reg(tag, 6'h1C, {24'd0, e});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] txb;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    // reset state
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_led", {24'd0, led}, 32'd0);
    chk("rst_rdata_idle", rdata, 32'd0);
    rd_reg("rst_tl", 6'h04, 32'd0);
    rd_reg("rst_ucon", 6'h20, 32'd0);

    // timer reload
    wr_reg(6'h00, 32'hFFFF_FFFC);
    wr_reg(6'h04, 32'hFFFF_FFFC);
    wr_reg(6'h08, 32'd3);
    rd_reg("tl_0", 6'h04, 32'hFFFF_FFFC);
    rd_reg("tl_1", 6'h04, 32'hFFFF_FFFD);
    @(negedge clk);
    rd_reg("tl_3", 6'h04, 32'hFFFF_FFFF);
    rd_reg("tl_wrap", 6'h04, 32'hFFFF_FFFC);
    rd_reg("tcon_st", 6'h08, 32'd7);
    chk("irq_user", {31'd0, irq}, 32'd1);
    supervisor = 1'b1;
    #1 chk("irq_kernel", {31'd0, irq}, 32'd0);
    rd_reg("tcon_sticky", 6'h08, 32'd7);
    supervisor = 1'b0;
    wr_reg(6'h08, 32'd3);   // lands on a wrap edge: write wins
    chk("irq_clr", {31'd0, irq}, 32'd0);
    rd_reg("tcon_clr", 6'h08, 32'd3);
    wr_reg(6'h08, 32'd0);

    // I/O registers
    wr_reg(6'h0C, 32'h0000_00A5);
    wr_reg(6'h14, 32'h00FF_FABC);
    chk("led_pin", {24'd0, led}, 32'h A5);
    chk("digi_pin", {20'd0, digi}, 32'h ABC);
    switch = 8'h3C;
    rd_reg("switch", 6'h10, 32'h0000_003C);
    rd_reg("hole", 6'h24, 32'd0);
    rd_reg("digi_rb", 6'h14, 32'h0000_0ABC);
    addr = 32'h4000_000C;
    #1 chk("rdata_no_rd", rdata, 32'd0);

    // UART TX 0x55
    txb = 8'h55;
    tx_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_q.push_back(txb[i]);
    tx_q.push_back(1'b1);
    wr_reg(6'h18, 32'h55);
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          if (n % 4 == 2) chk($sformatf("tx_bit%0d", n / 4), {31'd0, uart_tx}, {31'd0, tx_q.pop_front()});
          @(negedge clk);
        end
      end
      begin
        repeat (8) @(negedge clk);
        wr_reg(6'h18, 32'hFF);
        rd_reg("ucon_busy", 6'h20, 32'd1);
        rd_reg("txd_rb", 6'h18, 32'h55);
      end
    join
    rd_reg("ucon_done", 6'h20, 32'd4);
    rd_reg("ucon_clr", 6'h20, 32'd0);
    chk("tx_idle", {31'd0, uart_tx}, 32'd1);

    // UART RX
    send_frame(8'h3A, 1'b1);
    rd_reg("ucon_rxv", 6'h20, 32'd2);
    rd_rxd("rxd_3a");
    rd_reg("ucon_rxclr", 6'h20, 32'd0);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    rd_reg("ucon_ovr", 6'h20, 32'h12);
    rd_rxd("rxd_ovr");
    rd_reg("ucon_ovrclr", 6'h20, 32'd0);

    // RX errors
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (12) @(negedge clk);
    rd_reg("ucon_glitch", 6'h20, 32'd0);
    send_frame(8'h77, 1'b1);
    send_frame(8'h5A, 1'b0);
    rd_reg("ucon_ferr", 6'h20, 32'h0A);
    rd_rxd("rxd_keep");
    rd_reg("ucon_ferrclr", 6'h20, 32'd0);

    // reset mid-TX
    wr_reg(6'h18, 32'h00);
    repeat (10) @(negedge clk);
    chk("tx_mid", {31'd0, uart_tx}, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_async_led", {24'd0, led}, 32'd0);
    chk("rst_async_digi", {20'd0, digi}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    rd_reg("rst2_ucon", 6'h20, 32'd0);
    rd_reg("rst2_th", 6'h00, 32'd0);
    rd_reg("rst2_tl", 6'h04, 32'd0);
    rd_reg("rst2_tcon", 6'h08, 32'd0);
    rd_reg("rst2_txd", 6'h18, 32'd0);
    rd_reg("rst2_rxd", 6'h1C, 32'd0);
    chk("rst2_tx", {31'd0, uart_tx}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
